// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, single-outstanding imem reads, instruction buffer, BEQ/BNE/J redirect.
// Optional IFU_PERF_EN adds perf_fetch_cnt / perf_flush_cnt counters.
module instr_fetch_unit #(
  parameter int               ADDR_W     = 32,
  parameter int               IBUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        funct,
  output logic [ADDR_W-1:0] pc_out,
`ifdef IFU_PERF_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_flush_cnt,
`endif
  input  logic              zero
);

  localparam int PW = $clog2(IBUF_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J   = 6'b000010;

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [31:0]       ins;
    logic [ADDR_W-1:0] pc;
  } ibuf_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, req_pc;
  ibuf_t             ibuf [IBUF_DEPTH];
  ibuf_t             head;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  logic              hs, push, redirect;
  logic [ADDR_W-1:0] pc4, br_off, target;

  assign head        = ibuf[rd_ptr];
  assign instr_valid = (count != '0);
  assign instr       = head.ins;
  assign pc_out      = head.pc;
  assign opcode      = instr[31:26];
  assign funct       = instr[5:0];
  assign imem_addr   = fetch_pc;
  assign hs          = instr_valid & instr_ready;

  assign pc4    = pc_out + ADDR_W'(4);
  assign br_off = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};

  always_comb begin
    redirect = 1'b0;
    target   = pc4 + br_off;
    if (hs) begin
      unique case (1'b1)
        (opcode == OP_BEQ): redirect = zero;
        (opcode == OP_BNE): redirect = ~zero;
        (opcode == OP_J): begin
          redirect = 1'b1;
          target   = {pc4[ADDR_W-1:28], instr[25:0], 2'b00};
        end
        default: ;
      endcase
    end
  end

  // a request is held back in a redirect cycle so it never targets the stale path
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (count < CW'(IBUF_DEPTH) && !redirect) begin
          imem_req  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect)
          state_nxt = imem_rvalid ? FETCH : DRAIN;
        else if (imem_rvalid) begin
          push      = 1'b1;
          state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_nxt = FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state <= state_nxt;
      if (redirect)
        fetch_pc <= target;
      else if (imem_req) begin
        fetch_pc <= fetch_pc + ADDR_W'(4);
        req_pc   <= fetch_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < IBUF_DEPTH; i++)
        ibuf[i] <= '{ins: '0, pc: RESET_PC};
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ibuf[wr_ptr] <= '{ins: imem_rdata, pc: req_pc};
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (hs) rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, hs})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

`ifdef IFU_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (hs)       perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: latency-randomized memory, ISA-level fetch-stream model.
// Define IFU_PERF_EN to also check the perf counters.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  localparam int          AW    = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [5:0]  opcode, funct;
  logic [31:0] pc_out;
  logic        zero = 1'b0;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  instr_fetch_unit #(.ADDR_W(AW), .IBUF_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opcode(opcode), .funct(funct), .pc_out(pc_out),
`ifdef IFU_PERF_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt),
`endif
    .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic        z;
    int          cyc;
  } hs_t;

  hs_t         hs_q[$];
  logic [31:0] req_q[$];
  int          req_cyc_q[$];
  logic        v_q[$];
  logic [31:0] prog [logic [31:0]];

  int          checks = 0;
  int          errors = 0;
  int          cyc, pcnt, proto_err, field_err;
  bit          pend, last_req;
  logic [31:0] paddr;
  int          lat_min = 1, lat_max = 1, ready_pct = 100, zero_force = -1;
  bit          hold_en = 0;
  logic [31:0] hold_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    return {6'h00, a[21:2], 6'h20};
  endfunction

  function automatic logic ref_taken(input logic [31:0] ins, input logic z);
    logic [5:0] op;
    op = ins[31:26];
    return (op == 6'h02) || (op == 6'h04 && z) || (op == 6'h05 && !z);
  endfunction

  function automatic logic [31:0] ref_next(input logic [31:0] pc,
                                           input logic [31:0] ins,
                                           input logic        z);
    logic [5:0] op;
    int         off;
    op  = ins[31:26];
    off = int'($signed(ins[15:0])) * 4;
    if ((op == 6'h04 && z) || (op == 6'h05 && !z))
      return pc + 32'd4 + 32'(off);
    if (op == 6'h02)
      return ((pc + 32'd4) & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
    return pc + 32'd4;
  endfunction

  task automatic clear_logs();
    hs_q.delete(); req_q.delete(); req_cyc_q.delete(); v_q.delete();
    cyc = 0; proto_err = 0; field_err = 0; pend = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0; instr_ready = 1'b0; imem_rvalid = 1'b0; zero = 1'b0;
    hold_en = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_logs();
  endtask

  // one clock cycle: memory response, random ready/zero, then record what the DUT shows
  task automatic step();
    @(negedge clk);
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pend) begin
      pcnt--;
      if (pcnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(paddr);
        pend        = 0;
      end
    end
    instr_ready = (int'($urandom_range(99)) < ready_pct) &&
                  !(hold_en && instr_valid && pc_out == hold_pc);
    zero = (zero_force < 0) ? 1'($urandom) : 1'(zero_force);
    #1;
    v_q.push_back(instr_valid);
    last_req = imem_req;
    if (instr_valid && (opcode !== instr[31:26] || funct !== instr[5:0]))
      field_err++;
    if (imem_req) begin
      if (pend || imem_rvalid) proto_err++;
      req_q.push_back(imem_addr);
      req_cyc_q.push_back(cyc);
      pend  = 1;
      pcnt  = int'($urandom_range(lat_max, lat_min));
      paddr = imem_addr;
    end
    if (instr_valid && instr_ready)
      hs_q.push_back('{pc: pc_out, ins: instr, z: zero, cyc: cyc});
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++;
    if (imem_addr !== RPC) begin errors++; $display("FAIL rst_addr: got %h expected %h", imem_addr, RPC); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
    checks++;
    if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h expected 0", instr); end
    checks++;
    if (pc_out !== RPC) begin errors++; $display("FAIL rst_pc_out: got %h expected %h", pc_out, RPC); end
`ifdef IFU_PERF_EN
    checks++;
    if (perf_fetch_cnt !== 0 || perf_flush_cnt !== 0) begin
      errors++; $display("FAIL rst_perf: got %0d/%0d expected 0/0", perf_fetch_cnt, perf_flush_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b expected 0", imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp;
    prog.delete();
    lat_min = 1; lat_max = 1; ready_pct = 100; zero_force = -1;
    apply_reset();
    repeat (12) step();
    checks++;
    if (req_q.size() < 3 || req_q[0] !== 32'h0 || req_q[1] !== 32'h4 || req_q[2] !== 32'h8) begin
      errors++; $display("FAIL seq_addr: got %0d reqs first=%h expected 0,4,8", req_q.size(),
                         req_q.size() > 0 ? req_q[0] : 32'hx);
    end
    checks++;
    if (req_cyc_q.size() < 1 || req_cyc_q[0] != 1) begin
      errors++; $display("FAIL seq_first_req_cycle: got %0d expected 1",
                         req_cyc_q.size() > 0 ? req_cyc_q[0] : -1);
    end
    checks++;
    if (hs_q.size() < 3 || hs_q[0].cyc != 3 || hs_q[1].cyc != 5 || hs_q[2].cyc != 7) begin
      errors++; $display("FAIL seq_rate: got %0d handshakes expected cycles 3,5,7", hs_q.size());
    end
    exp = RPC;
    foreach (hs_q[i]) begin
      checks++;
      if (hs_q[i].pc !== exp || hs_q[i].ins !== mem_word(exp)) begin
        errors++; $display("FAIL seq_stream[%0d]: got pc=%h ins=%h expected pc=%h ins=%h",
                           i, hs_q[i].pc, hs_q[i].ins, exp, mem_word(exp));
      end
      exp = ref_next(exp, mem_word(exp), hs_q[i].z);
    end
    checks++;
    if (proto_err != 0 || field_err != 0) begin
      errors++; $display("FAIL seq_proto: got %0d/%0d violations expected 0", proto_err, field_err);
    end
  endtask

  task automatic test_beq();
    int k, nr;
    for (int pass = 0; pass < 2; pass++) begin
      prog.delete();
      prog[32'h8] = {6'h04, 5'd1, 5'd2, 16'h0004};
      lat_min = 1; lat_max = 1; ready_pct = 100; zero_force = (pass == 0) ? 1 : 0;
      apply_reset();
      repeat (20) step();
      k = -1; nr = -1;
      foreach (hs_q[i]) if (k < 0 && hs_q[i].pc == 32'h8) k = i;
      if (k >= 0)
        foreach (req_cyc_q[i]) if (nr < 0 && req_cyc_q[i] >= hs_q[k].cyc) nr = i;
      if (pass == 0) begin
        checks++;
        if (nr < 0 || req_q[nr] !== 32'h1C) begin
          errors++; $display("FAIL beq_taken_addr: got %h expected 0000001c", nr < 0 ? 32'hx : req_q[nr]);
        end
        checks++;
        if (k < 0 || k + 1 >= hs_q.size() || hs_q[k+1].pc !== 32'h1C) begin
          errors++; $display("FAIL beq_taken_next: handshake after 0x8 not at 0000001c (k=%0d)", k);
        end
      end else begin
        checks++;
        if (k < 0 || k + 1 >= hs_q.size() || hs_q[k+1].pc !== 32'hC) begin
          errors++; $display("FAIL beq_not_taken_next: handshake after 0x8 not at 0000000c (k=%0d)", k);
        end
      end
    end
  endtask

  task automatic test_jump();
    int k, nr;
    prog.delete();
    prog[32'h10] = {6'h02, 26'h40};
    lat_min = 1; lat_max = 1; ready_pct = 100; zero_force = -1;
    apply_reset();
    repeat (24) step();
    k = -1; nr = -1;
    foreach (hs_q[i]) if (k < 0 && hs_q[i].pc == 32'h10) k = i;
    if (k >= 0)
      foreach (req_cyc_q[i]) if (nr < 0 && req_cyc_q[i] >= hs_q[k].cyc) nr = i;
    checks++;
    if (nr < 0 || req_q[nr] !== 32'h100) begin
      errors++; $display("FAIL j_addr: got %h expected 00000100", nr < 0 ? 32'hx : req_q[nr]);
    end
    checks++;
    if (k < 0 || v_q.size() <= hs_q[k].cyc || v_q[hs_q[k].cyc] !== 1'b0) begin
      errors++; $display("FAIL j_valid_after: instr_valid not 0 in cycle after jump (k=%0d)", k);
    end
    checks++;
    if (k < 0 || k + 1 >= hs_q.size() || hs_q[k+1].pc !== 32'h100) begin
      errors++; $display("FAIL j_next: handshake after jump not at 00000100 (k=%0d)", k);
    end
  endtask

  task automatic test_drain();
    int r, hits;
    logic [31:0] exp;
    prog.delete();
    prog[32'h10] = {6'h05, 5'd1, 5'd2, 16'h0008};
    lat_min = 4; lat_max = 4; ready_pct = 100; zero_force = 0;
    apply_reset();
    hold_en = 1; hold_pc = 32'h10;
    repeat (70) begin
      step();
      if (hold_en && req_q.size() > 0 && req_q[req_q.size()-1] == 32'h14) hold_en = 0;
    end
    r = -1; hits = 0;
    foreach (req_q[i]) if (r < 0 && req_q[i] == 32'h14) r = i;
    foreach (hs_q[i]) if (hs_q[i].pc == 32'h14 || hs_q[i].ins == mem_word(32'h14)) hits++;
    checks++;
    if (r < 0 || r + 1 >= req_q.size() || req_q[r+1] !== 32'h34) begin
      errors++; $display("FAIL drain_target: request after 0x14 not at 00000034 (r=%0d)", r);
    end
    checks++;
    if (r < 0 || r + 1 >= req_q.size() || req_cyc_q[r+1] != req_cyc_q[r] + 5) begin
      errors++; $display("FAIL drain_timing: target request cycle wrong (r=%0d)", r);
    end
    checks++;
    if (hits != 0) begin errors++; $display("FAIL drain_dropped: got %0d presentations of 0x14 expected 0", hits); end
    exp = RPC;
    foreach (hs_q[i]) begin
      checks++;
      if (hs_q[i].pc !== exp || hs_q[i].ins !== mem_word(exp)) begin
        errors++; $display("FAIL drain_stream[%0d]: got pc=%h expected pc=%h", i, hs_q[i].pc, exp);
      end
      exp = ref_next(exp, mem_word(exp), hs_q[i].z);
    end
    checks++;
    if (proto_err != 0) begin errors++; $display("FAIL drain_proto: got %0d expected 0", proto_err); end
  endtask

  task automatic test_stall();
    logic [31:0] exp;
    prog.delete();
    lat_min = 1; lat_max = 1; ready_pct = 0; zero_force = -1;
    apply_reset();
    repeat (10) step();
    checks++;
    if (req_q.size() != DEPTH) begin
      errors++; $display("FAIL stall_reqs: got %0d expected %0d", req_q.size(), DEPTH);
    end
    checks++;
    if (last_req !== 1'b0) begin errors++; $display("FAIL stall_req_low: got %b expected 0", last_req); end
    checks++;
    if (instr_valid !== 1'b1 || pc_out !== RPC) begin
      errors++; $display("FAIL stall_head: got valid=%b pc=%h expected 1/%h", instr_valid, pc_out, RPC);
    end
    ready_pct = 100;
    repeat (20) step();
    checks++;
    if (hs_q.size() < 5) begin errors++; $display("FAIL stall_drain_count: got %0d expected >=5", hs_q.size()); end
    exp = RPC;
    foreach (hs_q[i]) begin
      checks++;
      if (hs_q[i].pc !== exp || hs_q[i].ins !== mem_word(exp)) begin
        errors++; $display("FAIL stall_stream[%0d]: got pc=%h expected pc=%h", i, hs_q[i].pc, exp);
      end
      exp = ref_next(exp, mem_word(exp), hs_q[i].z);
    end
  endtask

  task automatic test_reset_mid_wait();
    int stale;
    prog.delete();
    lat_min = 4; lat_max = 4; ready_pct = 100; zero_force = -1;
    apply_reset();
    repeat (3) step();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RPC || instr_valid !== 1'b0 ||
        instr !== 32'h0 || pc_out !== RPC) begin
      errors++; $display("FAIL midrst_outputs: got req=%b addr=%h v=%b ins=%h pc=%h expected reset values",
                         imem_req, imem_addr, instr_valid, instr, pc_out);
    end
`ifdef IFU_PERF_EN
    checks++;
    if (perf_fetch_cnt !== 0 || perf_flush_cnt !== 0) begin
      errors++; $display("FAIL midrst_perf: got %0d/%0d expected 0/0", perf_fetch_cnt, perf_flush_cnt);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    lat_min = 1; lat_max = 1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    instr_ready = 1'b1;
    repeat (20) step();
    stale = 0;
    foreach (hs_q[i]) if (hs_q[i].ins == 32'hDEAD_BEEF) stale++;
    checks++;
    if (req_q.size() < 1 || req_q[0] !== RPC || req_cyc_q[0] != 1) begin
      errors++; $display("FAIL midrst_first_req: first post-reset request not at %h in cycle 1", RPC);
    end
    checks++;
    if (v_q.size() < 1 || v_q[0] !== 1'b0 || stale != 0) begin
      errors++; $display("FAIL midrst_stale: stale word presented (%0d times)", stale);
    end
    checks++;
    if (hs_q.size() < 1 || hs_q[0].ins !== mem_word(RPC) || hs_q[0].cyc != 3) begin
      errors++; $display("FAIL midrst_first_instr: first head not word(%h) in cycle 3", RPC);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    int          o, taken;
    logic [15:0] imm;
    prog.delete();
    for (int a = 0; a < 64; a++) begin
      o   = int'($urandom_range(32)) - 16;
      imm = o[15:0];
      case ($urandom_range(9))
        0: prog[32'(a * 4)] = {6'h04, 5'd1, 5'd2, imm};
        1: prog[32'(a * 4)] = {6'h05, 5'd3, 5'd4, imm};
        2: prog[32'(a * 4)] = {6'h02, 26'($urandom_range(63))};
        default: ;
      endcase
    end
    lat_min = 1; lat_max = 4; ready_pct = 70; zero_force = -1;
    apply_reset();
    repeat (3000) step();
    checks++;
    if (hs_q.size() < 100) begin errors++; $display("FAIL rand_progress: got %0d handshakes expected >=100", hs_q.size()); end
    exp = RPC; taken = 0;
    foreach (hs_q[i]) begin
      checks++;
      if (hs_q[i].pc !== exp || hs_q[i].ins !== mem_word(exp)) begin
        errors++; $display("FAIL rand_stream[%0d]: got pc=%h ins=%h expected pc=%h ins=%h",
                           i, hs_q[i].pc, hs_q[i].ins, exp, mem_word(exp));
      end
      if (ref_taken(mem_word(exp), hs_q[i].z)) taken++;
      exp = ref_next(exp, mem_word(exp), hs_q[i].z);
    end
    checks++;
    if (proto_err != 0 || field_err != 0) begin
      errors++; $display("FAIL rand_proto: got %0d/%0d violations expected 0", proto_err, field_err);
    end
    @(posedge clk);
    #1;
`ifdef IFU_PERF_EN
    checks++;
    if (perf_fetch_cnt !== 32'(hs_q.size()) || perf_flush_cnt !== 32'(taken)) begin
      errors++; $display("FAIL rand_perf: got %0d/%0d expected %0d/%0d",
                         perf_fetch_cnt, perf_flush_cnt, hs_q.size(), taken);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_beq();
    test_jump();
    test_drain();
    test_stall();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch front end. Supplies the instruction word and its opcode/funct fields to the control decoder, and resolves control flow using those same fields.
- Holds the fetch PC and issues single-outstanding reads to instruction memory. Buffers returned words in a small FIFO and presents them through a valid/ready handshake.
- Handles BEQ/BNE/J redirects: computes the target, flushes buffered words and discards any in-flight response.

Parameters:
- ADDR_W, 32, width of the PC and instruction memory address.
- IBUF_DEPTH, 2, instruction buffer entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- imem_req  out  1  read request; accepted in the cycle it is asserted.
- imem_addr  out  ADDR_W  read address; valid while imem_req=1.
- imem_rvalid  in  1  read data valid; exactly one per accepted request, latency of 1 or more cycles.
- imem_rdata  in  32  read data.
- instr_valid  out  1  buffer head is valid.
- instr_ready  in  1  downstream accepts the head (low = stall).
- instr  out  32  head instruction word.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- pc_out  out  ADDR_W  PC of the head instruction.
- zero  in  1  ALU zero flag for the instruction currently at the head; sampled on the handshake.

Behaviour:
- Reset (rst=0, asynchronous): state is IDLE; fetch_pc=RESET_PC; buffer empty.
  - Outputs: imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, pc_out=RESET_PC.
- Reset release: IDLE moves to FETCH on the first clk edge after release; the first imem_req follows in the next cycle.
- States:
  - IDLE: after reset only.
  - FETCH: may request.
  - WAIT: one request outstanding.
  - DRAIN: an outstanding response is to be discarded.
- Request rule: in FETCH, drive imem_req=1 with imem_addr=fetch_pc when the buffer has a free slot (count < IBUF_DEPTH).
  - On the edge: fetch_pc += 4, modulo 2^ADDR_W (wrap-around is silent); go to WAIT.
- WAIT:
  - On imem_rvalid, push {imem_rdata, requesting pc} into the buffer and go to FETCH.
  - No new request is issued in the rvalid cycle, so back-to-back fetch costs at least 2 cycles per word.
- Head and handshake:
  - instr, opcode, funct and pc_out are driven combinationally from the head entry.
  - A handshake occurs when instr_valid & instr_ready; it pops the head on the edge.
- Redirect evaluation, on the handshake cycle only:
  - BEQ (6'b000100) with zero=1, or BNE (6'b000101) with zero=0: target = pc_out + 4 + (sign-extended instr[15:0] << 2).
  - J (6'b000010): target = {pc_out+4 [ADDR_W-1:28], instr[25:0], 2'b00}.
  - Not-taken branches and all other opcodes: no redirect.
- Redirect effect, on the edge:
  - fetch_pc <= target; buffer cleared (count=0).
  - If a request is outstanding (WAIT), go to DRAIN; otherwise go to FETCH.
  - instr_valid=0 in the cycle after a redirect.
- DRAIN: the next imem_rvalid is dropped, then go to FETCH.
- Simultaneous events:
  - imem_rvalid in the same cycle as a redirect: the response is dropped (not pushed), and the state goes to FETCH, not DRAIN.
  - Push and pop in the same cycle: count is unchanged.
- Buffer full with instr_ready=0: no request; everything holds.
- Reset mid-transaction: any later imem_rvalid belonging to a pre-reset request must not be pushed. Reset forces IDLE, and IDLE ignores rvalid.
- The block never asserts imem_req while a request is outstanding.

Optional Feature:
- Macro: IFU_PERF_EN.
- Defined: adds outputs perf_fetch_cnt (out, 32) and perf_flush_cnt (out, 32), both reset to 0 and wrapping modulo 2^32.
  - perf_fetch_cnt increments once per handshake.
  - perf_flush_cnt increments once per redirect.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, memory latency 1, instr_ready=1, sequential program of ADDs → imem_addr sequence 0x0, 0x4, 0x8; each word appears at the head with matching pc_out; one instruction per 2 cycles.
- BEQ at 0x8 with imm=16'h0004 and zero=1 at handshake → next imem_req addr 0x1C; buffered word from 0xC never presented; same BEQ with zero=0 → fetch continues at 0xC.
- J at 0x10 with instr[25:0]=26'h40 → next fetched address 0x100; instr_valid=0 for the cycle after the handshake.
- Latency 4, BNE taken (zero=0) while a request for 0x14 is outstanding → 0x14 response dropped (DRAIN), then request at target; the dropped word is never seen on instr.
- Hold instr_ready=0 for 10 cycles → exactly IBUF_DEPTH requests issued, then imem_req stays 0; releasing drains the buffer in order.
- Assert rst low mid-WAIT, release, then deliver a stale imem_rvalid → outputs at reset values, stale word not presented, first post-reset addr = RESET_PC. With IFU_PERF_EN, counters read 0 after reset.
